// File: rtl/apb_mock_uart_pkg.sv
// apb_mock_uart_pkg
// Shared constants for the mock 16550-style UART: register indices,
// fixed read-back values, the DLAB bit position and the special characters
// that the line buffer reacts to.
package apb_mock_uart_pkg;

    // Register indices after the byte-address shift
    localparam logic [2:0] RBR_THR_DLL = 3'd0;
    localparam logic [2:0] IER_DLM     = 3'd1;
    localparam logic [2:0] IIR_FCR     = 3'd2;
    localparam logic [2:0] LCR         = 3'd3;
    localparam logic [2:0] MCR         = 3'd4;
    localparam logic [2:0] LSR         = 3'd5;
    localparam logic [2:0] MSR         = 3'd6;
    localparam logic [2:0] SCR         = 3'd7;

    // Fixed read-back values: transmitter always empty, nothing received,
    // no interrupt pending.
    localparam logic [7:0] LSR_VALUE = 8'h60;
    localparam logic [7:0] IIR_NOINT = 8'h01;
    localparam logic [7:0] IIR_FIFO  = 8'hC0;
    localparam logic [7:0] MSR_VALUE = 8'h00;
    localparam logic [7:0] RBR_VALUE = 8'h00;

    // Divisor-latch access bit inside LCR
    localparam int DLAB_BIT = 7;

    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;

endpackage

// File: rtl/apb_mock_uart_if.sv
// apb_mock_uart_if
// APB3 bus bundle between the SoC UART master port and the mock UART.
// Signal names carry the slave's point of view (_i into the slave, _o out).
//   psel_i, penable_i, pwrite_i, paddr_i, pwdata_i : master -> slave
//   prdata_o, pready_o, pslverr_o                  : slave -> master
interface apb_mock_uart_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic                 psel_i;
    logic                 penable_i;
    logic                 pwrite_i;
    logic [AddrWidth-1:0] paddr_i;
    logic [DataWidth-1:0] pwdata_i;
    logic [DataWidth-1:0] prdata_o;
    logic                 pready_o;
    logic                 pslverr_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_mock_uart_linebuf.sv
// apb_mock_uart_linebuf
// Collects characters written to THR into a line and flushes the line on
// newline or when the buffer fills. CR is dropped; the LF itself is never
// part of the line.
// Optional feature macro: MOCK_UART_PRINT_EN -- when defined, each flush is
// printed as "[UART] <line>" and a partial line is printed at end of sim.
// When undefined there is no console output but counting is unchanged.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   wr_i           : a THR character write commits this cycle
//   char_i         : character being written
//   count_o        : characters currently buffered
//   flush_o        : this write ends the current line
//   flush_len_o    : length of the line being flushed (valid with flush_o)
module apb_mock_uart_linebuf
    import apb_mock_uart_pkg::*;
#(
    parameter int LineBufDepth = 128,
    localparam int CntW = $clog2(LineBufDepth + 1),
    localparam int IdxW = $clog2(LineBufDepth)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            wr_i,
    input  logic [7:0]      char_i,
    output logic [CntW-1:0] count_o,
    output logic            flush_o,
    output logic [CntW-1:0] flush_len_o
);

    logic [CntW-1:0] count_q;
    logic [7:0]      line_q [LineBufDepth];
    logic            is_lf;
    logic            is_cr;
    logic            append;
    logic            full_flush;

    assign is_lf  = (char_i == CHAR_LF);
    assign is_cr  = (char_i == CHAR_CR);
    assign append = wr_i && !is_lf && !is_cr;
    // The character that brings the buffer to LineBufDepth entries is stored
    // and the line is flushed on the same edge.
    assign full_flush = append && (count_q == CntW'(LineBufDepth - 1));

    assign flush_o     = (wr_i && is_lf) || full_flush;
    assign flush_len_o = append ? count_q + CntW'(1) : count_q;
    assign count_o     = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (flush_o) begin
            count_q <= '0;
        end else if (append) begin
            count_q <= count_q + CntW'(1);
        end
    end

    // Character storage needs no reset: only entries below count_q are live.
    always_ff @(posedge clk_i) begin
        if (append) begin
            line_q[count_q[IdxW-1:0]] <= char_i;
        end
    end

`ifdef MOCK_UART_PRINT_EN
    function automatic string line_str(input int n);
        string s;
        s = "";
        for (int i = 0; i < n; i++) begin
            s = $sformatf("%s%c", s, line_q[i]);
        end
        return s;
    endfunction

    always @(posedge clk_i) begin
        if (rst_ni && flush_o) begin
            if (append) begin
                $display("[UART] %s%c", line_str(int'(count_q)), char_i);
            end else begin
                $display("[UART] %s", line_str(int'(count_q)));
            end
        end
    end

    final begin
        if (count_q != '0) begin
            $display("[UART] %s", line_str(int'(count_q)));
        end
    end
`else
    // Without printing the stored characters are never read back.
    logic unused_line;
    assign unused_line = ^line_q[0];
`endif

endmodule

// File: rtl/apb_mock_uart.sv
// apb_mock_uart
// APB3 slave modelling a 16550-style UART register file for simulation.
// THR writes feed a line buffer that is flushed to the console; LSR always
// reports the transmitter empty and RBR reads 0, so software never stalls.
// Zero wait states, no errors; reads are side-effect free.
// Optional feature macro: MOCK_UART_PRINT_EN (console output of flushed lines,
// handled in apb_mock_uart_linebuf).
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   bus     : APB3 slave modport (psel/penable/pwrite/paddr/pwdata in,
//             prdata/pready/pslverr out)
module apb_mock_uart
    import apb_mock_uart_pkg::*;
#(
    parameter int AddrWidth    = 32,
    parameter int DataWidth    = 32,
    parameter int RegShift     = 2,
    parameter int LineBufDepth = 128,
    localparam int CntW = $clog2(LineBufDepth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    apb_mock_uart_if.slave        bus
);

    logic [2:0] idx;
    logic       wr_en;
    logic       dlab;
    logic       thr_wr;
    logic [7:0] wdata;
    logic [7:0] rd_byte;

    logic [3:0] ier_q;
    logic [7:0] dll_q;
    logic [7:0] dlm_q;
    logic       fcr0_q;
    logic [7:0] lcr_q;
    logic [4:0] mcr_q;
    logic [7:0] scr_q;

    // Only the three index bits are decoded; the window aliases everywhere.
    assign idx    = bus.paddr_i[RegShift+2:RegShift];
    assign wdata  = bus.pwdata_i[7:0];
    assign wr_en  = bus.psel_i && bus.penable_i && bus.pwrite_i;
    assign dlab   = lcr_q[DLAB_BIT];
    assign thr_wr = wr_en && (idx == RBR_THR_DLL) && !dlab;

    logic unused_bus;
    assign unused_bus = ^{bus.paddr_i, bus.pwdata_i};

    assign bus.pready_o  = 1'b1;
    assign bus.pslverr_o = 1'b0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ier_q  <= '0;
            dll_q  <= '0;
            dlm_q  <= '0;
            fcr0_q <= 1'b0;
            lcr_q  <= '0;
            mcr_q  <= '0;
            scr_q  <= '0;
        end else if (wr_en) begin
            unique case (idx)
                RBR_THR_DLL: if (dlab) dll_q <= wdata;
                IER_DLM: begin
                    if (dlab) dlm_q <= wdata;
                    else      ier_q <= wdata[3:0];
                end
                // FIFO reset bits 1-2 self-clear, so only the enable is kept.
                IIR_FCR: fcr0_q <= wdata[0];
                LCR:     lcr_q  <= wdata;
                MCR:     mcr_q  <= wdata[4:0];
                SCR:     scr_q  <= wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_byte = '0;
        if (bus.psel_i) begin
            unique case (idx)
                RBR_THR_DLL: rd_byte = dlab ? dll_q : RBR_VALUE;
                IER_DLM:     rd_byte = dlab ? dlm_q : {4'b0, ier_q};
                IIR_FCR:     rd_byte = fcr0_q ? (IIR_FIFO | IIR_NOINT) : IIR_NOINT;
                LCR:         rd_byte = lcr_q;
                MCR:         rd_byte = {3'b0, mcr_q};
                LSR:         rd_byte = LSR_VALUE;
                MSR:         rd_byte = MSR_VALUE;
                SCR:         rd_byte = scr_q;
                default:     rd_byte = '0;
            endcase
        end
        bus.prdata_o = {{(DataWidth-8){1'b0}}, rd_byte};
    end

    logic [CntW-1:0] lb_count;
    logic            lb_flush;
    logic [CntW-1:0] lb_flush_len;

    apb_mock_uart_linebuf #(
        .LineBufDepth (LineBufDepth)
    ) u_linebuf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wr_i        (thr_wr),
        .char_i      (wdata),
        .count_o     (lb_count),
        .flush_o     (lb_flush),
        .flush_len_o (lb_flush_len)
    );

    logic unused_lb;
    assign unused_lb = ^{lb_count, lb_flush, lb_flush_len};

endmodule

// File: tb/tb_apb_mock_uart.sv
module tb_apb_mock_uart;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    apb_mock_uart_if #(.AddrWidth(32), .DataWidth(32)) bus ();

    apb_mock_uart #(
        .AddrWidth(32), .DataWidth(32), .RegShift(2), .LineBufDepth(128)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        else n_pass++;
    endtask

    // ---------------- reference model ----------------
    byte unsigned m_reg [8];   // LCR/SCR/etc. as software sees them
    byte unsigned m_dll, m_dlm;
    byte unsigned line_m [$];
    int dut_flushes = 0;
    int dut_last_len = 0;

    function automatic void m_reset();
        foreach (m_reg[i]) m_reg[i] = 0;
        m_dll = 0; m_dlm = 0;
        line_m.delete();
    endfunction

    function automatic bit m_dlab();
        return m_reg[3][7];
    endfunction

    function automatic byte unsigned m_read(input int idx);
        case (idx)
            0: return m_dlab() ? m_dll : 8'h00;
            1: return m_dlab() ? m_dlm : (m_reg[1] & 8'h0F);
            2: return m_reg[2][0] ? 8'hC1 : 8'h01;
            3: return m_reg[3];
            4: return m_reg[4] & 8'h1F;
            5: return 8'h60;
            6: return 8'h00;
            default: return m_reg[7];
        endcase
    endfunction

    // Would writing c to THR now end a line, and how long is that line?
    function automatic void m_predict(input byte unsigned c, output bit fl, output int len);
        fl = 0; len = 0;
        if (c == 8'h0A) begin fl = 1; len = line_m.size(); end
        else if (c != 8'h0D && line_m.size() + 1 == 128) begin fl = 1; len = 128; end
    endfunction

    function automatic void m_write(input int idx, input byte unsigned d);
        case (idx)
            0: if (m_dlab()) m_dll = d;
               else if (d == 8'h0A) line_m.delete();
               else if (d != 8'h0D) begin
                   line_m.push_back(d);
                   if (line_m.size() == 128) line_m.delete();
               end
            1: if (m_dlab()) m_dlm = d; else m_reg[1] = d;
            5, 6: ;
            default: m_reg[idx] = d;
        endcase
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_i) begin
        int idx;
        bit thr, efl;
        int elen;
        idx = int'(bus.paddr_i[4:2]);
        if (!rst_ni) m_reset();
        chk("pready", {31'b0, bus.pready_o}, 32'd1);
        chk("pslverr", {31'b0, bus.pslverr_o}, 32'd0);
        chk("prdata", bus.prdata_o, bus.psel_i ? {24'b0, m_read(idx)} : 32'd0);
        chk("count", 32'(dut.u_linebuf.count_o), 32'(line_m.size()));
        if (rst_ni) begin
            thr = bus.psel_i && bus.penable_i && bus.pwrite_i && idx == 0 && !m_dlab();
            efl = 0; elen = 0;
            if (thr) m_predict(bus.pwdata_i[7:0], efl, elen);
            chk("flush", {31'b0, dut.u_linebuf.flush_o}, {31'b0, efl});
            if (efl) chk("flush_len", 32'(dut.u_linebuf.flush_len_o), 32'(elen));
            if (dut.u_linebuf.flush_o) begin
                dut_flushes++;
                dut_last_len = int'(dut.u_linebuf.flush_len_o);
            end
            if (bus.psel_i && bus.penable_i && bus.pwrite_i) m_write(idx, bus.pwdata_i[7:0]);
        end
    end

    // ---------------- drivers ----------------
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd);
        @(posedge clk_i); #1;
        bus.psel_i = 1; bus.penable_i = 0; bus.pwrite_i = wr;
        bus.paddr_i = addr; bus.pwdata_i = wd;
        @(posedge clk_i); #1;
        bus.penable_i = 1;
        @(negedge clk_i);
        rd = bus.prdata_o;
        @(posedge clk_i); #1;
        bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] dummy;
        xfer(1'b1, addr, wd, dummy);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] d);
        xfer(1'b0, addr, 32'h0, d);
    endtask

    task automatic pulse_reset();
        @(posedge clk_i); #1; rst_ni = 0;
        @(posedge clk_i); #1; rst_ni = 1;
    endtask

    initial begin
        logic [31:0] r;
        int f0;
        bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0;
        bus.paddr_i = '0; bus.pwdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1;

        // Reset state and LSR
        rd(32'h14, r); chk("lsr_after_reset", r, 32'h60);
        rd(32'h1C, r); chk("scr_after_reset", r, 32'h00);

        // Scratch register, then reset clears it
        wr(32'h1C, 32'hFFFF_FFA5);
        rd(32'h1C, r); chk("scr_rw", r, 32'hA5);
        rd(32'hABC0_003C, r); chk("scr_alias", r, 32'hA5);
        pulse_reset();
        rd(32'h1C, r); chk("scr_reset", r, 32'h00);

        // Divisor latches under DLAB
        wr(32'h0C, 32'h80);
        wr(32'h00, 32'h1B);
        wr(32'h04, 32'h02);
        rd(32'h00, r); chk("dll", r, 32'h1B);
        rd(32'h04, r); chk("dlm", r, 32'h02);
        wr(32'h0C, 32'h03);
        rd(32'h00, r); chk("rbr", r, 32'h00);
        chk("no_char_buffered", 32'(dut.u_linebuf.count_o), 32'd0);

        // "Hi\r\n" -> one flush of length 2
        f0 = dut_flushes;
        wr(32'h00, 32'h48); wr(32'h00, 32'h69); wr(32'h00, 32'h0D);
        chk("hi_count_before_lf", 32'(dut.u_linebuf.count_o), 32'd2);
        wr(32'h00, 32'h0A);
        chk("hi_flushes", 32'(dut_flushes - f0), 32'd1);
        chk("hi_len", 32'(dut_last_len), 32'd2);
        chk("hi_count", 32'(dut.u_linebuf.count_o), 32'd0);

        // 128 x 'a' forces a flush, 129th starts a new line
        f0 = dut_flushes;
        for (int i = 0; i < 127; i++) wr(32'h00, 32'h61);
        chk("full_no_flush_yet", 32'(dut_flushes - f0), 32'd0);
        chk("full_count127", 32'(dut.u_linebuf.count_o), 32'd127);
        wr(32'h00, 32'h61);
        chk("full_flushes", 32'(dut_flushes - f0), 32'd1);
        chk("full_len", 32'(dut_last_len), 32'd128);
        chk("full_count0", 32'(dut.u_linebuf.count_o), 32'd0);
        wr(32'h00, 32'h61);
        chk("new_line_count", 32'(dut.u_linebuf.count_o), 32'd1);

        // FCR / IIR and read-only LSR
        wr(32'h08, 32'h07); rd(32'h08, r); chk("iir_fifo", r, 32'hC1);
        wr(32'h08, 32'h00); rd(32'h08, r); chk("iir_nofifo", r, 32'h01);
        wr(32'h14, 32'h00); rd(32'h14, r); chk("lsr_ro", r, 32'h60);

        // Reset mid-line discards characters without a flush
        f0 = dut_flushes;
        wr(32'h00, 32'h78);
        pulse_reset();
        chk("midline_reset_count", 32'(dut.u_linebuf.count_o), 32'd0);
        chk("midline_reset_noflush", 32'(dut_flushes - f0), 32'd0);

        // Write colliding with reset: reset wins
        @(posedge clk_i); #1;
        bus.psel_i = 1; bus.pwrite_i = 1; bus.paddr_i = 32'h1C; bus.pwdata_i = 32'h55;
        @(posedge clk_i); #1; bus.penable_i = 1; rst_ni = 0;
        @(posedge clk_i); #1; bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0; rst_ni = 1;
        rd(32'h1C, r); chk("reset_wins", r, 32'h00);

        // Randomized traffic against the model
        for (int t = 0; t < 700; t++) begin
            logic [31:0] a, d;
            int ix, sel;
            ix = $urandom_range(0, 7);
            a  = $urandom();
            a[4:2] = ix[2:0];
            d  = $urandom();
            if (ix == 0) begin
                sel = $urandom_range(0, 9);
                if (sel == 0) d[7:0] = 8'h0A;
                else if (sel == 1) d[7:0] = 8'h0D;
            end
            if (ix == 3 && $urandom_range(0, 2) != 0) d[7] = 1'b0;
            if ($urandom_range(0, 149) == 0) pulse_reset();
            else if ($urandom_range(0, 2) == 0) rd(a, r);
            else wr(a, d);
        end

        repeat (2) @(posedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_mock_uart.md
Name: apb_mock_uart

Overview:
- Simulation-oriented APB3 slave that models a 16550-style UART register file at the SoC UART port.
- Transmit-holding-register writes go to a line buffer, which is flushed to the simulator console.
- Register reads always report the transmitter empty and no receive data, so boot and printf software never stalls.
- Sits beside the SoC top; it is the only consumer of the SoC's uart_* APB master port.

Parameters:
- AddrWidth, 32, APB address width.
- DataWidth, 32, APB data width; register data occupies bits [7:0], upper bits read 0.
- RegShift, 2, byte-address to register-index shift; index = paddr_i[RegShift+2:RegShift].
- LineBufDepth, 128, characters held before a forced flush.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- penable_i  in  1  APB access phase
- pwrite_i  in  1  1 = write, 0 = read
- paddr_i  in  AddrWidth  byte address
- psel_i  in  1  slave select
- pwdata_i  in  DataWidth  write data
- prdata_o  out  DataWidth  read data
- pready_o  out  1  transfer ready
- pslverr_o  out  1  slave error

Behaviour:
- Reset is rst_ni, asynchronous, active-low; clock is clk_i.
- Reset values: all registers 0, line buffer empty, prdata_o 0.
- pready_o is tied to 1 and pslverr_o to 0 at all times.
- Access occurs when psel_i && penable_i. A write commits at that clk_i rising edge.
- prdata_o is combinational from paddr_i whenever psel_i=1, otherwise 0. Zero wait states; a read completes in the access cycle.
- Only paddr_i bits selecting the 3-bit index are decoded; higher bits are ignored, so the window aliases.
- DLAB is LCR[7].

Register map (index: read / write):
- 0: read RBR=0x00, or DLL when DLAB=1. Write THR (character) when DLAB=0, DLL when DLAB=1.
- 1: read/write IER[3:0] when DLAB=0, DLM[7:0] when DLAB=1.
- 2: read IIR = 0xC1 if FCR[0]=1, else 0x01 (no interrupt pending). Write FCR; only bit 0 is stored, and bits 1–2 self-clear.
- 3: LCR, 8 bits read/write.
- 4: MCR[4:0] read/write.
- 5: LSR, read-only, always 0x60 (THRE | TEMT). Writes are ignored.
- 6: MSR, read-only 0x00.
- 7: SCR, 8 bits read/write.

Line buffer:
- A THR write appends pwdata_i[7:0] to the line buffer.
- A flush happens when the character is 0x0A (newline), or when the buffer reaches LineBufDepth entries.
- On flush, the buffered line is emitted with the newline excluded, and the count returns to 0 in the same cycle.
- A 0x0D (carriage return) character is dropped and not buffered.
- Reset asserted mid-line discards the buffered characters with no output.
- Simultaneous write and reset: reset wins.
- A read has no side effects.

Optional Feature:
- Macro MOCK_UART_PRINT_EN.
- Defined: each flush prints "[UART] <line>" via $display. At end of simulation (final block) a non-empty buffer is also printed.
- Undefined: no console output. The buffer and counter still operate so register timing is identical, and the whole block is synthesizable.

Decomposition:
- Package apb_mock_uart_pkg holds:
  - register index localparams (RBR_THR_DLL=0 … SCR=7);
  - LSR_VALUE=0x60, IIR_NOINT=0x01, IIR_FIFO=0xC0;
  - the DLAB bit position.
- One sub-module, apb_mock_uart_linebuf: character append, flush detection, counter, and the print under the macro.

Test Plan:
- Reset, then read index 5 (paddr 0x14) → prdata_o = 0x60 with pready_o = 1 and pslverr_o = 0 in the same cycle.
- Write 0xA5 to SCR (0x1C), then read it → 0xA5. Assert reset mid-test, then read SCR → 0x00.
- Write LCR = 0x80, write 0x1B to 0x00 and 0x02 to 0x04 (index 1). Read 0x00 → 0x1B and 0x04 → 0x02, then:
  - write LCR = 0x03 and read 0x00 → 0x00 (RBR);
  - check that no character was buffered.
- Write 'H', 'i', 0x0D, 0x0A to THR → exactly one flush with line "Hi" (printed with MOCK_UART_PRINT_EN), and the count returns to 0.
- Write 128 × 'a' without a newline → a forced flush on the 128th write, and the 129th character starts a new line.
- Write FCR = 0x07 → IIR reads 0xC1. Write FCR = 0x00 → IIR reads 0x01. Write to LSR has no effect (still reads 0x60).
